mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data/address width.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  EX result valid.
- in_ready  out  1  stage can accept.
- flush  in  1  kill current op.
- alu_out  in  DWIDTH  effective address or ALU result.
- store_data  in  DWIDTH  forwarded rs2.
- ctrl_mem_rd  in  1  load.
- ctrl_mem_wr  in  1  store.
- mem_func  in  3  funct3 (FNC_* codes).
- rd_addr  in  5  destination register.
- ctrl_reg_we  in  1  writeback enable.
- mem_req  out  1  memory request.
- mem_we  out  4  byte write enables.
- mem_addr  out  DWIDTH  word-aligned address.
- mem_wdata  out  DWIDTH  lane-shifted store data.
- mem_ack  in  1  one-cycle completion; mem_rdata valid.
- mem_rdata  in  DWIDTH  read word.
- wb_valid  out  1  result valid, one cycle.
- wb_data  out  DWIDTH  writeback value.
- wb_rd  out  5  destination.
- wb_we  out  1  writeback enable.

Function
REQ-003 SHALL implement FSM IDLE, BUSY; in_ready = (state==IDLE).
REQ-004 SHALL accept an op when in_valid & in_ready & !flush; accepted fields registered.
REQ-005 Non-memory op SHALL stay IDLE; wb_valid=1, wb_data=alu_out, wb_rd/wb_we registered next cycle (latency 1).
REQ-006 Load/store accept SHALL move IDLE->BUSY; mem_req=1 from next cycle, mem_addr/mem_we/mem_wdata held stable until mem_ack.
REQ-007 mem_ack in BUSY SHALL drop mem_req next cycle, return IDLE, pulse wb_valid next cycle.
REQ-008 mem_ack outside BUSY SHALL be ignored.
REQ-009 mem_addr SHALL be {addr[DWIDTH-1:2],2'b00}.
REQ-010 Store lanes: SB we=4'b0001<<addr[1:0], data byte replicated x4; SH we=4'b0011<<addr[1:0], halfword replicated x2; SW we=4'b1111; loads we=0.
REQ-011 Load result SHALL shift mem_rdata right by 8*addr[1:0], then LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-012 Store completion SHALL pulse wb_valid with wb_we=0.
REQ-013 flush during BUSY SHALL NOT abort mem_req; op completes, its wb_valid suppressed.
REQ-014 flush in IDLE SHALL block acceptance; in-flight wb pulse that cycle unaffected.
REQ-015 wb_valid SHALL be 0 every cycle not named in REQ-005/007/012.

Reset
REQ-016 rst_n=0 at a rising edge SHALL force IDLE, mem_req=0, mem_we=0, wb_valid=0, wb_we=0, wb_data=0, wb_rd=0, mem_addr=0, mem_wdata=0.
REQ-017 Reset mid-BUSY SHALL abandon the op; late mem_ack ignored per REQ-008.

Configuration
REQ-018 MISALIGN_TRAP_EN defined: SHALL add outputs exc_misaligned (1) and exc_addr (DWIDTH); halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL skip BUSY, issue no mem_req, pulse exc_misaligned with exc_addr=alu_out and wb_valid=0 next cycle.
REQ-019 MISALIGN_TRAP_EN undefined: no exception ports; misaligned accesses SHALL use REQ-009/010/011 masking unchanged.

Structure
REQ-020 FSM state encodings and the lane/extend constants SHALL live in a shared package alongside Opcode.vh FNC_* codes.
REQ-021 Load alignment/extension SHALL be a combinational sub-module load_align.

Verification
REQ-022 ADD result 0x12345678, rd=5 -> next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5, wb_we=1, no mem_req.
REQ-023 SB addr 0x1003 data 0xAB -> mem_addr 0x1000, mem_we 4'b1000, mem_wdata 0xABABABAB held over 3 wait cycles; after ack wb_valid=1, wb_we=0.
REQ-024 LB addr 0x2001, mem_rdata 0x0000_8000 ack after 2 cycles -> wb_data 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x2002 rdata 0x8001_0000 -> 0xFFFF8001.
REQ-025 flush asserted in BUSY of LW -> mem_req held to ack, no wb_valid, in_ready=1 after.
REQ-026 rst_n=0 during BUSY, stray mem_ack next cycle -> IDLE, mem_req=0, wb_valid stays 0.
REQ-027 With MISALIGN_TRAP_EN, LW addr 0x3002 -> no mem_req, exc_misaligned pulse, exc_addr 0x3002.

Source files
------------

// File: rtl/mem_access_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the memory-access pipeline stage:
//   - state_e      : FSM state encoding (IDLE, BUSY)
//   - FNC_*        : funct3 codes for loads and stores
//   - WE_*         : byte-lane write-enable patterns for a 32-bit data bus
//   - store_we()   : byte-enable pattern for a store at a byte offset
//   - misaligned() : natural-alignment test used by the optional trap
// ----------------------------------------------------------------------------
package mem_access_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // funct3 codes. Loads and stores share the size encoding in bits [1:0];
  // bit 2 selects zero extension for loads.
  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  // Size field (funct3[1:0]).
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Byte-lane enables before shifting by the byte offset.
  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_BYTE = 4'b0001;
  localparam logic [3:0] WE_HALF = 4'b0011;
  localparam logic [3:0] WE_WORD = 4'b1111;

  // Byte enables for a store. Misaligned halfwords shift lanes off the top
  // of the word; that truncation is the intended behaviour without the trap.
  function automatic logic [3:0] store_we(input logic [2:0] func,
                                          input logic [1:0] offset);
    logic [3:0] we;
    case (func[1:0])
      SIZE_BYTE: we = WE_BYTE << offset;
      SIZE_HALF: we = WE_HALF << offset;
      SIZE_WORD: we = WE_WORD;
      default:   we = WE_NONE;
    endcase
    return we;
  endfunction

  // True when the access is not naturally aligned.
  function automatic logic misaligned(input logic [2:0] func,
                                      input logic [1:0] offset);
    logic bad;
    case (func[1:0])
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// ----------------------------------------------------------------------------
// load_align
// Combinational load data alignment: shifts the read word right by the byte
// offset, then sign- or zero-extends according to funct3.
// Ports:
//   rdata_i  [DWIDTH] read word from memory
//   offset_i [2]      byte offset of the access (addr[1:0])
//   func_i   [3]      funct3 of the load (FNC_L*)
//   data_o   [DWIDTH] writeback value
// ----------------------------------------------------------------------------
module load_align
  import mem_access_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] rdata_i,
  input  logic [1:0]        offset_i,
  input  logic [2:0]        func_i,
  output logic [DWIDTH-1:0] data_o
);

  logic [DWIDTH-1:0] shifted;

  // NOTE: every output of a combinational block gets a value on every path,
  // either through a default first assignment or a default case arm; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (func_i)
      FNC_LB:  data_o = {{(DWIDTH-8){shifted[7]}},   shifted[7:0]};
      FNC_LH:  data_o = {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
      FNC_LBU: data_o = {{(DWIDTH-8){1'b0}},         shifted[7:0]};
      FNC_LHU: data_o = {{(DWIDTH-16){1'b0}},        shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// ----------------------------------------------------------------------------
// mem_access
// Memory-access pipeline stage. Accepts one EX result at a time; non-memory
// ops pass straight to writeback after one cycle, loads and stores raise a
// request that is held until mem_ack and then complete to writeback.
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned halfword and
// word accesses (exc_misaligned / exc_addr ports) instead of issuing them.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid / in_ready      EX handshake
//   flush                    kill current op
//   alu_out, store_data      effective address / ALU result, rs2 data
//   ctrl_mem_rd/wr, mem_func load/store select and funct3
//   rd_addr, ctrl_reg_we     destination register and writeback enable
//   mem_req/we/addr/wdata    memory request (held until mem_ack)
//   mem_ack, mem_rdata       memory completion and read word
//   wb_valid/data/rd/we      one-cycle writeback pulse
//   exc_misaligned, exc_addr misaligned-access trap (MISALIGN_TRAP_EN only)
//
// The byte-lane logic assumes DWIDTH = 32 (four byte lanes).
// ----------------------------------------------------------------------------
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [DWIDTH-1:0] alu_out,
  input  logic [DWIDTH-1:0] store_data,
  input  logic              ctrl_mem_rd,
  input  logic              ctrl_mem_wr,
  input  logic [2:0]        mem_func,
  input  logic [4:0]        rd_addr,
  input  logic              ctrl_reg_we,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [DWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DWIDTH-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_we
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              exc_misaligned,
  output logic [DWIDTH-1:0] exc_addr
`endif
);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_e            state_q;
  logic              mem_req_q;
  logic [3:0]        mem_we_q;
  logic [DWIDTH-1:0] mem_addr_q;
  logic [DWIDTH-1:0] mem_wdata_q;
  logic              wb_valid_q;
  logic [DWIDTH-1:0] wb_data_q;
  logic [4:0]        wb_rd_q;
  logic              wb_we_q;

  // Fields of the in-flight memory op.
  logic [2:0]        func_q;
  logic [1:0]        offset_q;
  logic [4:0]        rd_q;
  logic              reg_we_q;
  logic              is_load_q;
  logic              flushed_q;   // flush seen while BUSY: suppress writeback

`ifdef MISALIGN_TRAP_EN
  logic              exc_q;
  logic [DWIDTH-1:0] exc_addr_q;
`endif

  // --------------------------------------------------------------------------
  // Next-value computation for an op accepted this cycle
  // --------------------------------------------------------------------------
  logic              accept;
  logic              is_mem;
  logic              trap_d;
  logic [1:0]        offset_d;
  logic [3:0]        mem_we_d;
  logic [DWIDTH-1:0] mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_d;
  logic [DWIDTH-1:0] load_data;

  assign accept   = in_valid && (state_q == ST_IDLE) && !flush;
  assign is_mem   = ctrl_mem_rd || ctrl_mem_wr;
  assign offset_d = alu_out[1:0];

`ifdef MISALIGN_TRAP_EN
  assign trap_d = misaligned(mem_func, offset_d);
`else
  assign trap_d = 1'b0;
`endif

  always_comb begin
    mem_addr_d  = {alu_out[DWIDTH-1:2], 2'b00};
    mem_we_d    = WE_NONE;
    mem_wdata_d = '0;
    // A store takes precedence if both control bits are set.
    if (ctrl_mem_wr) begin
      mem_we_d = store_we(mem_func, offset_d);
      case (mem_func[1:0])
        SIZE_BYTE: mem_wdata_d = {(DWIDTH/8){store_data[7:0]}};
        SIZE_HALF: mem_wdata_d = {(DWIDTH/16){store_data[15:0]}};
        default:   mem_wdata_d = store_data;
      endcase
    end
  end

  load_align #(.DWIDTH(DWIDTH)) u_load_align (
    .rdata_i  (mem_rdata),
    .offset_i (offset_q),
    .func_i   (func_q),
    .data_o   (load_data)
  );

  // --------------------------------------------------------------------------
  // FSM with registered outputs
  // --------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= WE_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      func_q      <= '0;
      offset_q    <= '0;
      rd_q        <= '0;
      reg_we_q    <= 1'b0;
      is_load_q   <= 1'b0;
      flushed_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      exc_q       <= 1'b0;
      exc_addr_q  <= '0;
`endif
    end else begin
      // Pulses default low; only the completing branches raise them.
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      exc_q      <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= alu_out;
              wb_rd_q    <= rd_addr;
              wb_we_q    <= ctrl_reg_we;
            end else if (trap_d) begin
`ifdef MISALIGN_TRAP_EN
              exc_q      <= 1'b1;
              exc_addr_q <= alu_out;
`endif
            end else begin
              state_q     <= ST_BUSY;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= mem_addr_d;
              mem_we_q    <= mem_we_d;
              mem_wdata_q <= mem_wdata_d;
              func_q      <= mem_func;
              offset_q    <= offset_d;
              rd_q        <= rd_addr;
              reg_we_q    <= ctrl_reg_we;
              is_load_q   <= !ctrl_mem_wr;
              flushed_q   <= 1'b0;
            end
          end
        end

        ST_BUSY: begin
          // The request runs to completion even when flushed; only the
          // writeback pulse is dropped. A flush on the ack cycle counts too.
          if (flush) begin
            flushed_q <= 1'b1;
          end
          if (mem_ack) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= WE_NONE;
            wb_valid_q <= !(flushed_q || flush);
            wb_data_q  <= is_load_q ? load_data : '0;
            wb_rd_q    <= rd_q;
            wb_we_q    <= is_load_q && reg_we_q && !(flushed_q || flush);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = (state_q == ST_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign wb_we     = wb_we_q;
`ifdef MISALIGN_TRAP_EN
  assign exc_misaligned = exc_q;
  assign exc_addr       = exc_addr_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// ----------------------------------------------------------------------------
// tb_mem_access
// Directed self-checking bench for mem_access (DWIDTH = 32). Inputs change
// and outputs are sampled 1 ns after each rising edge. Define
// MISALIGN_TRAP_EN for both bench and RTL to cover the trap build.
// ----------------------------------------------------------------------------
module tb_mem_access;

  localparam int DW = 32;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_SB  = 3'b000;
  localparam logic [2:0] F_SH  = 3'b001;
  localparam logic [2:0] F_SW  = 3'b010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [DW-1:0] alu_out;
  logic [DW-1:0] store_data;
  logic          ctrl_mem_rd;
  logic          ctrl_mem_wr;
  logic [2:0]    mem_func;
  logic [4:0]    rd_addr;
  logic          ctrl_reg_we;
  logic          mem_req;
  logic [3:0]    mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [4:0]    wb_rd;
  logic          wb_we;
`ifdef MISALIGN_TRAP_EN
  logic          exc_misaligned;
  logic [DW-1:0] exc_addr;
`endif

  int checks   = 0;
  int failures = 0;

  mem_access #(.DWIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .alu_out     (alu_out),
    .store_data  (store_data),
    .ctrl_mem_rd (ctrl_mem_rd),
    .ctrl_mem_wr (ctrl_mem_wr),
    .mem_func    (mem_func),
    .rd_addr     (rd_addr),
    .ctrl_reg_we (ctrl_reg_we),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_we       (wb_we)
`ifdef MISALIGN_TRAP_EN
    ,
    .exc_misaligned (exc_misaligned),
    .exc_addr       (exc_addr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] observed,
                       input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle, then withdraw in_valid.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] func,
                       input logic [DW-1:0] addr, input logic [DW-1:0] sdata,
                       input logic [4:0] dst, input logic we);
    in_valid    = 1'b1;
    ctrl_mem_rd = rd;
    ctrl_mem_wr = wr;
    mem_func    = func;
    alu_out     = addr;
    store_data  = sdata;
    rd_addr     = dst;
    ctrl_reg_we = we;
    tick();
    in_valid    = 1'b0;
    ctrl_mem_rd = 1'b0;
    ctrl_mem_wr = 1'b0;
  endtask

  // Hold mem_ack high for one cycle with the given read word.
  task automatic ack(input logic [DW-1:0] rdata);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
  endtask

  // Store: check lanes/data right after acceptance, then complete.
  task automatic store_op(input string tag, input logic [2:0] func,
                          input logic [DW-1:0] addr, input logic [DW-1:0] sdata,
                          input logic [DW-1:0] exp_addr, input logic [3:0] exp_we,
                          input logic [DW-1:0] exp_wdata);
    issue(1'b0, 1'b1, func, addr, sdata, 5'd0, 1'b0);
    check({tag, "_addr"},  mem_addr,  exp_addr);
    check({tag, "_we"},    {28'd0, mem_we}, {28'd0, exp_we});
    check({tag, "_wdata"}, mem_wdata, exp_wdata);
    ack('0);
    check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_wbwe"}, {31'd0, wb_we}, 32'd0);
  endtask

  // Load with two wait cycles before ack.
  task automatic load_op(input string tag, input logic [2:0] func,
                         input logic [DW-1:0] addr, input logic [DW-1:0] rdata,
                         input logic [4:0] dst, input logic [DW-1:0] exp_data);
    issue(1'b1, 1'b0, func, addr, '0, dst, 1'b1);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_we"},  {28'd0, mem_we}, 32'd0);
    tick();
    tick();
    ack(rdata);
    check({tag, "_wbv"},  {31'd0, wb_valid}, 32'd1);
    check({tag, "_data"}, wb_data, exp_data);
    check({tag, "_rd"},   {27'd0, wb_rd}, {27'd0, dst});
    check({tag, "_wbwe"}, {31'd0, wb_we}, 32'd1);
    check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    flush       = 1'b0;
    alu_out     = '0;
    store_data  = '0;
    ctrl_mem_rd = 1'b0;
    ctrl_mem_wr = 1'b0;
    mem_func    = '0;
    rd_addr     = '0;
    ctrl_reg_we = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;

    // Reset state
    tick();
    tick();
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_req",   {31'd0, mem_req}, 32'd0);
    check("rst_we",    {28'd0, mem_we}, 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wbv",   {31'd0, wb_valid}, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    check("rst_wbrd",  {27'd0, wb_rd}, 32'd0);
    check("rst_wbwe",  {31'd0, wb_we}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Non-memory op: one-cycle writeback, no request
    issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, '0, 5'd5, 1'b1);
    check("add_wbv",  {31'd0, wb_valid}, 32'd1);
    check("add_data", wb_data, 32'h1234_5678);
    check("add_rd",   {27'd0, wb_rd}, 32'd5);
    check("add_wbwe", {31'd0, wb_we}, 32'd1);
    check("add_req",  {31'd0, mem_req}, 32'd0);
    tick();
    check("add_pulse", {31'd0, wb_valid}, 32'd0);

    // SB with three wait cycles: request fields stay stable
    issue(1'b0, 1'b1, F_SB, 32'h0000_1003, 32'h0000_00AB, 5'd0, 1'b0);
    check("sb_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("sb_req",   {31'd0, mem_req}, 32'd1);
      check("sb_addr",  mem_addr, 32'h0000_1000);
      check("sb_we",    {28'd0, mem_we}, 32'h8);
      check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      check("sb_wbv0",  {31'd0, wb_valid}, 32'd0);
      tick();
    end
    ack('0);
    check("sb_reqdrop", {31'd0, mem_req}, 32'd0);
    check("sb_wbv",     {31'd0, wb_valid}, 32'd1);
    check("sb_wbwe",    {31'd0, wb_we}, 32'd0);
    check("sb_ready1",  {31'd0, in_ready}, 32'd1);
    tick();
    check("sb_pulse",   {31'd0, wb_valid}, 32'd0);

    // Other store sizes
    store_op("sh", F_SH, 32'h0000_1002, 32'h0000_1234, 32'h0000_1000, 4'b1100, 32'h1234_1234);
    store_op("sw", F_SW, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0000_1008, 4'b1111, 32'hDEAD_BEEF);

    // Load extension
    load_op("lb",  F_LB,  32'h0000_2001, 32'h0000_8000, 5'd7, 32'hFFFF_FF80);
    load_op("lbu", F_LBU, 32'h0000_2001, 32'h0000_8000, 5'd8, 32'h0000_0080);
    load_op("lh",  F_LH,  32'h0000_2002, 32'h8001_0000, 5'd9, 32'hFFFF_8001);
    load_op("lw",  F_LW,  32'h0000_2004, 32'hCAFE_F00D, 5'd10, 32'hCAFE_F00D);

    // Flush while BUSY: request held to ack, writeback suppressed
    issue(1'b1, 1'b0, F_LW, 32'h0000_4000, '0, 5'd3, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_req",   {31'd0, mem_req}, 32'd1);
    check("fl_addr",  mem_addr, 32'h0000_4000);
    ack(32'h1111_1111);
    check("fl_wbv",   {31'd0, wb_valid}, 32'd0);
    check("fl_reqdn", {31'd0, mem_req}, 32'd0);
    check("fl_ready", {31'd0, in_ready}, 32'd1);

    // Flush in IDLE blocks acceptance of a load
    flush = 1'b1;
    issue(1'b1, 1'b0, F_LW, 32'h0000_4100, '0, 5'd4, 1'b1);
    flush = 1'b0;
    check("fi_req",   {31'd0, mem_req}, 32'd0);
    check("fi_ready", {31'd0, in_ready}, 32'd1);
    check("fi_wbv",   {31'd0, wb_valid}, 32'd0);

    // Flush does not disturb the writeback pulse already in flight
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0055, '0, 5'd9, 1'b1);
    flush = 1'b1;
    check("ff_wbv",  {31'd0, wb_valid}, 32'd1);
    check("ff_data", wb_data, 32'h0000_0055);
    tick();
    flush = 1'b0;
    check("ff_pulse", {31'd0, wb_valid}, 32'd0);

    // Reset mid-BUSY, then a stray ack is ignored
    issue(1'b1, 1'b0, F_LW, 32'h0000_5000, '0, 5'd6, 1'b1);
    check("rb_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ack(32'h2222_2222);
    check("rb_ready", {31'd0, in_ready}, 32'd1);
    check("rb_req0",  {31'd0, mem_req}, 32'd0);
    check("rb_wbv",   {31'd0, wb_valid}, 32'd0);
    tick();
    check("rb_wbv2",  {31'd0, wb_valid}, 32'd0);

`ifdef MISALIGN_TRAP_EN
    // Misaligned word load traps without a request
    issue(1'b1, 1'b0, F_LW, 32'h0000_3002, '0, 5'd4, 1'b1);
    check("mt_req",   {31'd0, mem_req}, 32'd0);
    check("mt_exc",   {31'd0, exc_misaligned}, 32'd1);
    check("mt_addr",  exc_addr, 32'h0000_3002);
    check("mt_wbv",   {31'd0, wb_valid}, 32'd0);
    check("mt_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("mt_pulse", {31'd0, exc_misaligned}, 32'd0);
`else
    // Misaligned word load goes through with plain masking/shifting
    issue(1'b1, 1'b0, F_LW, 32'h0000_3002, '0, 5'd4, 1'b1);
    check("ma_req",  {31'd0, mem_req}, 32'd1);
    check("ma_addr", mem_addr, 32'h0000_3000);
    ack(32'hAABB_CCDD);
    check("ma_wbv",  {31'd0, wb_valid}, 32'd1);
    check("ma_data", wb_data, 32'h0000_AABB);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
